pwm_duty_ramp: RTL and testbench
================================

# pwm_duty_ramp

Soft-start / fade generator placed directly upstream of the PWM stage. It accepts a target duty over a valid/ready handshake and steps its registered `duty` output toward that target by a programmable amount. Steps occur only on PWM period boundaries, every `rate+1` periods, so the PWM stage never sees a mid-period jump. It removes inrush and brightness steps on motor and LED loads.

## Interface
Parameters:
- `N`, 8: PWM counter width; `duty` spans 0..2^N (N+1 bits).
- `RATE_BITS`, 16: width of the period-prescaler setting.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `tgt_duty`  in  N+1  requested target; values above 2^N are clamped to 2^N at capture.
- `tgt_valid`  in  1  target request.
- `tgt_ready`  out  1  block can accept a target; combinational, equals (state==IDLE).
- `step`  in  N  duty increment per step; value 0 is treated as 1.
- `rate`  in  RATE_BITS  a step is taken every `rate+1` period ticks.
- `period_tick`  in  1  one-cycle pulse at each PWM period wrap (PWM counter at max while its timer tick is high).
- `abort`  in  1  stop ramp and hold current duty.
- `duty`  out  N+1  registered duty value fed to the PWM stage.
- `busy`  out  1  registered, high in RAMP.
- `done`  out  1  registered one-cycle pulse when `duty` reaches the target.

## Operation
- States:
  - IDLE: `tgt_ready`=1; handshake fires on `tgt_valid && tgt_ready`.
    - On fire: latch the clamped target into `tgt_q` and clear the prescaler.
    - If `tgt_q` != `duty`, go to RAMP.
    - Otherwise stay in IDLE and pulse `done`.
  - RAMP: `tgt_ready`=0; `tgt_valid` is ignored.
    - Prescaler increments on each `period_tick`.
    - When `period_tick` && prescaler==`rate`: prescaler<=0 and one step is taken.
- Step arithmetic, computed in N+2 bits with no wrap:
  - Up (`duty` < `tgt_q`): `duty` <= (`duty`+`step` >= `tgt_q`) ? `tgt_q` : `duty`+`step`.
  - Down (`duty` > `tgt_q`): `duty` <= (`duty`-`tgt_q` <= `step`) ? `tgt_q` : `duty`-`step`.
  - Never overshoots the target.
- On the edge that writes `duty`==`tgt_q`: state<=IDLE, `busy`<=0, `done`<=1 for one cycle.
- `abort` in RAMP: state<=IDLE and `duty` holds its value; no `done` pulse.
  - `abort` beats a step in the same cycle.
  - `abort` in IDLE has no effect.
- `rate`, `step` and `period_tick` are sampled live each cycle; the caller holds them stable during a ramp.

## Timing
- Reset (`reset_n`=0 at a rising edge): state=IDLE, `duty`=0, `tgt_q`=0, prescaler=0, `busy`=0, `done`=0. `tgt_ready` reads 1 in the first cycle after release.
- Accept at edge k: `busy`=1 from cycle k+1.
  - A `period_tick` coincident with the accept cycle is not counted.
- First step lands on the edge of the (`rate`+1)-th `period_tick` after acceptance. `duty` changes in the following cycle, aligned to the new PWM period.
- Full ramp length: ceil(|tgt_q−duty_start|/max(step,1)) × (`rate`+1) period ticks.
- `done` is high in the same cycle the final `duty` value first appears; `tgt_ready` is 1 in that cycle. A new target is accepted back-to-back.
- `rate`=0: a step on every `period_tick`.
- Reset mid-ramp: all state returns to reset values at that edge; the ramp is lost.

## Structure
- Shared package `pwm_pkg`:
  - state enum {IDLE, RAMP};
  - localparam `DUTY_MAX` = 2^N;
  - saturating step function shared with the PWM stage's duty clamp.
- One natural sub-module, `pwm_period_div`: a `RATE_BITS` counter with sync clear, enable=`period_tick`, terminal=`rate`, output `step_en`.
- The top holds the FSM, `tgt_q` and the `duty` register.

## Test plan
- Reset, then up-ramp: N=8, `rate`=0, `step`=10, target 50, `period_tick` every 256 clk.
  - `duty` goes 10,20,30,40,50, each change one cycle after a tick.
  - `done` pulses once with `duty`=50; `busy` falls in that same cycle.
- Down-ramp with non-multiple and prescale: from 50, target 3, `step`=20, `rate`=2.
  - `duty` goes 30,10,3, each spaced 3 ticks apart; no underflow.
- Clamp and step 0: target 300, `step`=0, `rate`=0, `duty` at 254.
  - `duty` goes 255 then 256; `done` pulses; `duty` never exceeds 256.
- Equal target: target == current `duty` (e.g. 0 after reset).
  - `done` pulses the cycle after accept; `busy` stays 0.
- Abort vs. step collision: assert `abort` in the same cycle as a qualifying `period_tick`.
  - `duty` holds its pre-step value, state is IDLE, no `done`, `tgt_ready`=1.
- Mid-ramp reset, and `tgt_valid` ignored during RAMP:
  - a second target offered while `busy`=1 is not accepted;
  - `reset_n`=0 mid-ramp gives `duty`=0 and `busy`=0 at the next edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty path.
// Holds the ramp FSM states and the saturating step/clamp arithmetic.
package pwm_pkg;

   typedef enum logic {
      IDLE,
      RAMP
   } state_t;

   localparam int N_DEF = 8;
   localparam int DUTY_MAX = 1 << N_DEF;

   // One step from cur toward tgt; never passes tgt, step 0 acts as 1
   function automatic int unsigned sat_step(
      input int unsigned cur,
      input int unsigned tgt,
      input int unsigned stp
   );
      int unsigned s;
      s = (stp == 0) ? 1 : stp;
      if (cur < tgt)
         return (cur + s >= tgt) ? tgt : cur + s;
      else if (cur > tgt)
         return (cur - tgt <= s) ? tgt : cur - s;
      else
         return cur;
   endfunction

   // Limit a requested duty to the full-on value
   function automatic int unsigned clamp(
      input int unsigned v,
      input int unsigned lim
   );
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/pwm_period_div.sv
// Period prescaler: counts period ticks and fires every rate+1 of them.
// Clear has priority; step_en is the terminal-count qualifier.
module pwm_period_div #(
   parameter int RATE_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic [RATE_BITS-1:0] rate,
   output logic                 step_en
);

   logic [RATE_BITS-1:0] cnt;

   assign step_en = en && (cnt == rate);

   // Count enabled ticks, wrap to zero at the terminal value
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == rate)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start / fade generator feeding the PWM stage.
// Steps duty toward a handshaken target only on PWM period boundaries.
import pwm_pkg::*;

module pwm_duty_ramp #(
   parameter int N = 8,
   parameter int RATE_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N:0]           tgt_duty,
   input  logic                 tgt_valid,
   output logic                 tgt_ready,
   input  logic [N-1:0]         step,
   input  logic [RATE_BITS-1:0] rate,
   input  logic                 period_tick,
   input  logic                 abort,
   output logic [N:0]           duty,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned LIM = 1 << N;

   state_t     state;
   logic [N:0] tgt_q;
   logic [N:0] tgt_cl;
   logic [N:0] nxt;
   logic       fire;
   logic       tick_en;
   logic       step_en;

   assign tgt_ready = (state == IDLE);
   assign fire      = tgt_valid && tgt_ready;
   assign tick_en   = period_tick && (state == RAMP);
   assign tgt_cl    = (N+1)'(clamp(32'(tgt_duty), LIM));
   assign nxt       = (N+1)'(sat_step(32'(duty), 32'(tgt_q), 32'(step)));

   pwm_period_div #(
      .RATE_BITS(RATE_BITS)
   ) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (fire),
      .en      (tick_en),
      .rate    (rate),
      .step_en (step_en)
   );

   // Ramp FSM: accept target, step on prescaled ticks, finish or abort
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         duty  <= '0;
         tgt_q <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (fire) begin
                  tgt_q <= tgt_cl;
                  if (tgt_cl != duty) begin
                     state <= RAMP;
                     busy  <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RAMP: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (step_en) begin
                  duty <= nxt;
                  if (nxt == tgt_q) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp.
// Directed plan scenarios plus randomized ramps against a plan-queue model.
module tb_pwm_duty_ramp;

   localparam int N = 8;
   localparam int RB = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [N:0]    tgt_duty = '0;
   logic          tgt_valid = 1'b0;
   logic          tgt_ready;
   logic [N-1:0]  step = '0;
   logic [RB-1:0] rate = '0;
   logic          period_tick = 1'b0;
   logic          abort = 1'b0;
   logic [N:0]    duty;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   int m_duty = 0;
   int m_busy = 0;
   int m_done = 0;
   int m_ticks = 0;
   int plan[$];

   pwm_duty_ramp #(
      .N(N),
      .RATE_BITS(RB)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tgt_duty    (tgt_duty),
      .tgt_valid   (tgt_valid),
      .tgt_ready   (tgt_ready),
      .step        (step),
      .rate        (rate),
      .period_tick (period_tick),
      .abort       (abort),
      .duty        (duty),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance the model over one edge using the current inputs
   task automatic model_edge();
      int t;
      int d;
      int s;
      if (!reset_n) begin
         m_duty = 0;
         m_busy = 0;
         m_done = 0;
         m_ticks = 0;
         plan.delete();
         return;
      end
      m_done = 0;
      if (m_busy == 0) begin
         if (tgt_valid) begin
            t = (int'(tgt_duty) > (1 << N)) ? (1 << N) : int'(tgt_duty);
            s = (step == 0) ? 1 : int'(step);
            d = m_duty;
            plan.delete();
            while (d != t) begin
               if (d < t) d = (t - d > s) ? d + s : t;
               else       d = (d - t > s) ? d - s : t;
               plan.push_back(d);
            end
            m_ticks = 0;
            if (plan.size() == 0) m_done = 1;
            else m_busy = 1;
         end
      end else if (abort) begin
         m_busy = 0;
         plan.delete();
      end else if (period_tick) begin
         m_ticks++;
         if (m_ticks == int'(rate) + 1) begin
            m_ticks = 0;
            m_duty = plan.pop_front();
            if (plan.size() == 0) begin
               m_busy = 0;
               m_done = 1;
            end
         end
      end
   endtask

   // One clock: update model, take the edge, compare outputs after it
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check("duty", 32'(duty), 32'(m_duty));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("tgt_ready", 32'(tgt_ready), 32'(m_busy == 0));
   endtask

   task automatic offer(input int t);
      tgt_duty = (N+1)'(t);
      tgt_valid = 1'b1;
      cycle();
      tgt_valid = 1'b0;
   endtask

   task automatic run_ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         period_tick = 1'b0;
         for (int j = 0; j < gap - 1; j++) cycle();
         period_tick = 1'b1;
         cycle();
      end
      period_tick = 1'b0;
   endtask

   initial begin
      int guard;

      // reset
      reset_n = 1'b0;
      cycle();
      cycle();
      reset_n = 1'b1;
      cycle();
      check("rst_ready", 32'(tgt_ready), 1);
      check("rst_duty", 32'(duty), 0);

      // up-ramp 0 -> 50, step 10, rate 0
      step = 8'd10;
      rate = '0;
      offer(50);
      run_ticks(5, 256);
      cycle();
      check("up_final", 32'(duty), 50);

      // down-ramp 50 -> 3, step 20, rate 2
      step = 8'd20;
      rate = 16'd2;
      offer(3);
      run_ticks(9, 8);
      cycle();
      check("down_final", 32'(duty), 3);

      // move to 254, then clamp 300 with step 0
      step = 8'd251;
      rate = '0;
      offer(254);
      run_ticks(1, 4);
      step = 8'd0;
      offer(300);
      run_ticks(2, 4);
      cycle();
      check("clamp_final", 32'(duty), 256);

      // equal target
      offer(256);
      check("eq_done", 32'(done), 1);
      check("eq_busy", 32'(busy), 0);
      cycle();

      // abort colliding with a qualifying tick
      step = 8'd10;
      offer(100);
      abort = 1'b1;
      period_tick = 1'b1;
      cycle();
      abort = 1'b0;
      period_tick = 1'b0;
      check("abort_duty", 32'(duty), 256);
      check("abort_ready", 32'(tgt_ready), 1);
      check("abort_done", 32'(done), 0);
      cycle();

      // mid-ramp reset, second target ignored while busy
      step = 8'd1;
      offer(0);
      run_ticks(3, 3);
      offer(200);
      check("ignored_busy", 32'(busy), 1);
      run_ticks(2, 3);
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      check("mrst_duty", 32'(duty), 0);
      check("mrst_busy", 32'(busy), 0);
      cycle();

      // randomized ramps
      for (int r = 0; r < 40; r++) begin
         step = 8'($urandom_range(0, 40));
         if ($urandom_range(0, 9) == 0) step = '0;
         rate = 16'($urandom_range(0, 2));
         period_tick = 1'($urandom_range(0, 1));
         offer($urandom_range(0, 511));
         guard = 0;
         while (m_busy != 0 && guard < 5000) begin
            period_tick = 1'($urandom_range(0, 1));
            abort = ($urandom_range(0, 199) == 0);
            tgt_valid = ($urandom_range(0, 7) == 0);
            tgt_duty = (N+1)'($urandom_range(0, 511));
            reset_n = ($urandom_range(0, 499) != 0);
            cycle();
            guard++;
         end
         check("ramp_bound", 32'(guard < 5000), 1);
         reset_n = 1'b1;
         abort = 1'b0;
         tgt_valid = 1'b0;
         period_tick = 1'b0;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
